// File: rtl/signed_adder_16.sv
// ---------------------------------------------------------------------------
// signed_adder_16
//   Registered two's-complement adder for the datapath arithmetic stage.
//   The sum of a and b appears on y one clock after in_valid, together with
//   signed overflow and unsigned carry-out of that same sum. A sticky
//   overflow flag accumulates overflow events for software/debug readback.
//
// Parameters
//   WIDTH     operand / result width in bits (two's complement)
//   SATURATE  0: wrap-around result on overflow
//             1: clamp to the most positive / most negative value
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   a/b valid this cycle; the sum is captured
//   a, b        in   signed operands, WIDTH bits
//   clr_sticky  in   synchronous clear of ovf_sticky (a same-edge set wins)
//   y           out  registered sum, WIDTH bits
//   out_valid   out  y/ovf/carry were updated from an accepted pair
//   ovf         out  signed overflow of the sum currently on y
//   carry       out  unsigned carry-out of the sum currently on y
//   ovf_sticky  out  set on any overflow since reset / last clear
// ---------------------------------------------------------------------------
module signed_adder_16 #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             ovf,
  output logic             carry,
  output logic             ovf_sticky
);

  localparam int MSB = WIDTH - 1;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]   sum_full;
  logic             ovf_next;
  logic             carry_next;
  logic [WIDTH-1:0] y_next;

  // Full-precision sum of the sign-extended operands.
  assign sum_full = {a[MSB], a} + {b[MSB], b};

  // Overflow: like-signed operands producing a result of the other sign.
  assign ovf_next = (a[MSB] == b[MSB]) && (sum_full[MSB] != a[MSB]);

  // The top bit of the sign-extended sum is a[MSB] ^ b[MSB] ^ (carry into
  // that bit), and the carry into that bit is exactly the unsigned carry-out
  // of a + b, so it can be recovered without a second adder.
  assign carry_next = sum_full[WIDTH] ^ a[MSB] ^ b[MSB];

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    y_next = sum_full[WIDTH-1:0];
    if (SATURATE && ovf_next) begin
      // On overflow both operands share a sign; a non-negative a means the
      // true result lies above the representable range.
      y_next = a[MSB] ? MAX_NEG : MAX_POS;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      carry     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y     <= y_next;
        ovf   <= ovf_next;
        carry <= carry_next;
      end
    end
  end

  // Set has priority over clear so an overflow on the clearing edge is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (in_valid && ovf_next) begin
      ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_signed_adder_16.sv
// ---------------------------------------------------------------------------
// tb_signed_adder_16
//   Drives a wrap-around instance and a saturating instance of
//   signed_adder_16 from the same stimulus. A directed table of operand
//   pairs with hand-derived results is followed by hand-written reset and
//   sticky-flag sequences and a randomized stream compared against an
//   integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_signed_adder_16;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         clr_sticky;

  logic [W-1:0] y_w, y_s;
  logic         out_valid_w, out_valid_s;
  logic         ovf_w, ovf_s;
  logic         carry_w, carry_s;
  logic         sticky_w, sticky_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (results on the outputs after the last edge).
  logic [W-1:0] m_y_w, m_y_s;
  logic         m_ovf, m_carry, m_valid, m_sticky;

  always #5 clk = ~clk;

  signed_adder_16 #(.WIDTH(W), .SATURATE(1'b0)) dut_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .clr_sticky (clr_sticky),
    .y          (y_w),
    .out_valid  (out_valid_w),
    .ovf        (ovf_w),
    .carry      (carry_w),
    .ovf_sticky (sticky_w)
  );

  signed_adder_16 #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .clr_sticky (clr_sticky),
    .y          (y_s),
    .out_valid  (out_valid_s),
    .ovf        (ovf_s),
    .carry      (carry_s),
    .ovf_sticky (sticky_s)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         valid;
    logic         clr;
    logic [W-1:0] exp_y_w;
    logic [W-1:0] exp_y_s;
    logic         exp_ovf;
    logic         exp_carry;
    logic         exp_sticky;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on the operand values.
  task automatic model_step(input logic [W-1:0] ma, input logic [W-1:0] mb,
                            input logic mv, input logic mc);
    int          sa, sb, sum, usum;
    logic [31:0] sum_bits;
    logic        o;
    sa       = $signed(ma);
    sb       = $signed(mb);
    sum      = sa + sb;
    usum     = int'(ma) + int'(mb);
    sum_bits = sum;
    o        = (sum > 32767) || (sum < -32768);
    if (mv) begin
      m_y_w   = sum_bits[W-1:0];
      m_y_s   = (sum > 32767) ? 16'h7FFF : (sum < -32768) ? 16'h8000 : sum_bits[W-1:0];
      m_ovf   = o;
      m_carry = (usum > 65535);
    end
    m_valid  = mv;
    m_sticky = (m_sticky && !mc) || (mv && o);
  endtask

  task automatic model_reset();
    m_y_w = '0; m_y_s = '0; m_ovf = 1'b0; m_carry = 1'b0;
    m_valid = 1'b0; m_sticky = 1'b0;
  endtask

  // Drive inputs just after an edge, clock once, sample 1 time unit later.
  task automatic apply(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tv, input logic tc);
    a = ta; b = tb; in_valid = tv; clr_sticky = tc;
    @(posedge clk);
    #1;
    model_step(ta, tb, tv, tc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".y_wrap"},    32'(y_w),         32'h0);
    check({tag, ".y_sat"},     32'(y_s),         32'h0);
    check({tag, ".out_valid"}, 32'(out_valid_w), 32'h0);
    check({tag, ".ovf"},       32'(ovf_w),       32'h0);
    check({tag, ".carry"},     32'(carry_w),     32'h0);
    check({tag, ".sticky"},    32'(sticky_w),    32'h0);
    check({tag, ".sticky_s"},  32'(sticky_s),    32'h0);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".y_wrap"},    32'(y_w),         32'(m_y_w));
    check({tag, ".y_sat"},     32'(y_s),         32'(m_y_s));
    check({tag, ".ovf"},       32'(ovf_w),       32'(m_ovf));
    check({tag, ".ovf_s"},     32'(ovf_s),       32'(m_ovf));
    check({tag, ".carry"},     32'(carry_w),     32'(m_carry));
    check({tag, ".carry_s"},   32'(carry_s),     32'(m_carry));
    check({tag, ".out_valid"}, 32'(out_valid_w), 32'(m_valid));
    check({tag, ".out_vld_s"}, 32'(out_valid_s), 32'(m_valid));
    check({tag, ".sticky"},    32'(sticky_w),    32'(m_sticky));
    check({tag, ".sticky_s"},  32'(sticky_s),    32'(m_sticky));
  endtask

  initial begin
    //          a        b        v     clr   y_wrap   y_sat    ovf   carry sticky
    vecs[0]  = '{16'd50,  16'd150, 1'b1, 1'b0, 16'd200, 16'd200, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'd1250, 16'hFAEC, 1'b1, 1'b0, 16'hFFCE, 16'hFFCE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'hFAEC, 16'd1300, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{16'h8000, 16'hFFFF, 1'b1, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{16'h8000, 16'h7FFF, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{16'h1234, 16'hEDCC, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
    // Clear with no overflow on the edge.
    vecs[8]  = '{16'h0001, 16'h0002, 1'b1, 1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0};
    // Clear on the same edge as an overflowing pair: set wins.
    vecs[9]  = '{16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 16'hFFFE, 16'h7FFF, 1'b1, 1'b0, 1'b1};
    // No valid: results hold, out_valid drops.
    vecs[10] = '{16'h0005, 16'h0005, 1'b0, 1'b0, 16'hFFFE, 16'h7FFF, 1'b1, 1'b0, 1'b1};

    // Reset held with random inputs toggling and the clock running.
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      a = W'($urandom); b = W'($urandom);
      in_valid = 1'b1; clr_sticky = 1'b0;
      @(posedge clk);
      #1;
    end
    check_all_zero("reset_hold");

    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].valid, vecs[i].clr);
      check($sformatf("vec%0d.y_wrap", i), 32'(y_w),      32'(vecs[i].exp_y_w));
      check($sformatf("vec%0d.y_sat", i),  32'(y_s),      32'(vecs[i].exp_y_s));
      check($sformatf("vec%0d.ovf", i),    32'(ovf_w),    32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d.ovf_s", i),  32'(ovf_s),    32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d.carry", i),  32'(carry_w),  32'(vecs[i].exp_carry));
      check($sformatf("vec%0d.out_valid", i), 32'(out_valid_w), 32'(vecs[i].valid));
      check($sformatf("vec%0d.sticky", i), 32'(sticky_w), 32'(vecs[i].exp_sticky));
      check($sformatf("vec%0d.sticky_s", i), 32'(sticky_s), 32'(vecs[i].exp_sticky));
    end

    // A second idle cycle keeps holding, with sticky unchanged.
    apply(16'h1111, 16'h2222, 1'b0, 1'b0);
    check("hold2.y_wrap",    32'(y_w),         32'hFFFE);
    check("hold2.out_valid", 32'(out_valid_w), 32'h0);

    // Clear without overflow after the hold.
    apply(16'h0000, 16'h0000, 1'b0, 1'b1);
    check("clr_idle.sticky", 32'(sticky_w), 32'h0);
    check("clr_idle.y_wrap", 32'(y_w),      32'hFFFE);

    // Randomized stream against the reference model; the model is already
    // in step with the table sequence above.
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      // Bias some pairs toward the extremes so overflow is exercised often.
      if ($urandom_range(0, 3) == 0) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
      apply(ra, rb, ($urandom_range(0, 4) != 0), ($urandom_range(0, 7) == 0));
      check_model($sformatf("rand%0d", i));
    end

    // Asynchronous reset mid-stream: outputs drop without a clock edge.
    apply(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
    check_model("pre_async");
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("async_rst_hold");
    rst_n = 1'b1;
    model_reset();
    apply(16'd50, 16'd150, 1'b1, 1'b0);
    check_model("post_async");
    check("post_async.y", 32'(y_w), 32'd200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_adder_16.md
Name: signed_adder_16

Overview:
- Registered 16-bit two's-complement adder for the datapath arithmetic stage.
- Adds signed operands a and b, presents the sum on y one clock after a valid input, and reports signed overflow.
- Supports wrap-around or saturating arithmetic, selected by a parameter.
- Includes a sticky overflow flag for software/debug readback.

Parameters:
- WIDTH, 16, operand and result width in bits (two's complement).
- SATURATE, 0, 0 = wrap-around result on overflow; 1 = clamp to max/min representable value.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a/b valid this cycle; sum is captured.
- a  input  WIDTH  signed operand A.
- b  input  WIDTH  signed operand B.
- clr_sticky  input  1  synchronous clear of ovf_sticky.
- y  output  WIDTH  signed registered sum.
- out_valid  output  1  y/ovf updated from an accepted operand pair this cycle.
- ovf  output  1  signed overflow of the sum currently on y.
- carry  output  1  unsigned carry-out of the sum currently on y.
- ovf_sticky  output  1  set on any overflow since reset/clear.

Behaviour:
- Reset: rst_n low asynchronously forces y=0, out_valid=0, ovf=0, carry=0, ovf_sticky=0. Registers hold these values while rst_n is low. Normal operation resumes at the first rising clk edge after deassertion.
- Full-precision sum: s = sign-extend(a) + sign-extend(b), WIDTH+1 bits.
- Overflow: ovf_next = (a[MSB]==b[MSB]) && (s[WIDTH-1] != a[MSB]).
- Carry: carry_next = unsigned carry out of a+b (bit WIDTH of the zero-extended sum).
- Result when SATURATE=0: y_next = s[WIDTH-1:0] (wrap-around).
- Result when SATURATE=1 and ovf_next: y_next = 0x7FFF if a is positive, else 0x8000. Otherwise y_next = s[WIDTH-1:0].
- Latency: exactly 1 cycle. Operands sampled at edge N with in_valid=1 appear on y/ovf/carry after edge N, with out_valid=1 for that single cycle.
- in_valid=0: y, ovf and carry hold their previous values; out_valid=0 next cycle.
- Back-to-back: in_valid high every cycle gives full throughput, one result per cycle. No stalls and no backpressure.
- ovf_sticky:
  - Set on any edge where in_valid=1 and ovf_next=1.
  - Cleared by clr_sticky=1 at an edge.
  - If set and clear occur on the same edge, set wins.
- Async reset asserted mid-stream discards the in-flight result. No output glitches to nonzero while rst_n is low.
- Boundary values:
  - 0x7FFF+0x0001 overflows.
  - 0x8000+0xFFFF overflows.
  - 0x8000+0x7FFF = -1 with no overflow.
  - a+(-a) = 0 with carry=1 for a != 0.
- Purely synchronous datapath apart from the reset; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> y=0, out_valid=0, ovf=0, ovf_sticky=0; release and drive a=50, b=150, in_valid=1 -> next cycle y=200, ovf=0, out_valid=1.
- Mixed sign: a=1250, b=-1300 -> y=-50 (0xFFCE), ovf=0, carry=0. Then a=-1300, b=1300 -> y=0, carry=1.
- Positive overflow: a=32767, b=1 -> SATURATE=0: y=-32768, ovf=1; SATURATE=1: y=32767, ovf=1. ovf_sticky=1 in both cases and persists after a following a=1, b=1 (y=2, ovf=0).
- Negative overflow: a=-32768, b=-1 -> SATURATE=0: y=32767, ovf=1, carry=1; SATURATE=1: y=-32768. Also a=-32768, b=32767 -> y=-1, ovf=0.
- Hold and streaming:
  - in_valid pulses for 3 consecutive pairs -> three consecutive correct results, each with out_valid=1.
  - in_valid=0 afterwards -> y holds the last sum, out_valid=0.
- Sticky/reset corners:
  - clr_sticky with no overflow -> ovf_sticky=0.
  - clr_sticky on the same edge as an overflowing pair -> ovf_sticky=1.
  - rst_n pulsed low mid-stream -> outputs 0 immediately, asynchronously.
